// File: rtl/bus_fabric.sv
// bus_fabric: CPU bus decoder and single-outstanding transaction sequencer.
// Routes each latched request to one page-mapped target, completes it back
// through cpu_wait, aborts hung targets on a watchdog, and keeps a sticky
// first-error log for timeouts and unmapped accesses.
module bus_fabric #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_TARGETS = 3,
  parameter int unsigned PAGE_BITS   = 8,
  parameter logic [NUM_TARGETS*PAGE_BITS-1:0] TARGET_BASE = {8'hFF, 8'h80, 8'h00},
  parameter logic [NUM_TARGETS*PAGE_BITS-1:0] TARGET_LAST = {8'hFF, 8'hFE, 8'h7F},
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 8'hFF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADDR_WIDTH-1:0]             cpu_addr,
  input  logic [DATA_WIDTH-1:0]             cpu_wdata,
  input  logic                              cpu_read,
  input  logic                              cpu_write,
  output logic [DATA_WIDTH-1:0]             cpu_rdata,
  output logic                              cpu_wait,
  output logic [ADDR_WIDTH-1:0]             t_addr,
  output logic [DATA_WIDTH-1:0]             t_wdata,
  output logic [NUM_TARGETS-1:0]            t_read,
  output logic [NUM_TARGETS-1:0]            t_write,
  input  logic [NUM_TARGETS*DATA_WIDTH-1:0] t_rdata,
  input  logic [NUM_TARGETS-1:0]            t_wait,
  output logic                              err_valid,
  output logic                              err_timeout,
  output logic [ADDR_WIDTH-1:0]             err_addr,
  input  logic                              err_clear
);

  // Watchdog counts up to TIMEOUT exactly, so it never needs to wrap.
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [NUM_TARGETS-1:0]  r_sel;
  logic                    r_is_write;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_err_valid;
  logic                    r_err_timeout;
  logic [ADDR_WIDTH-1:0]   r_err_addr;

  logic                    w_req;
  logic [PAGE_BITS-1:0]    w_page;
  logic [NUM_TARGETS-1:0]  w_hit;
  logic                    w_sel_wait;
  logic [DATA_WIDTH-1:0]   w_sel_rdata;
  logic                    w_cnt_max;
  logic                    w_unmapped;
  logic                    w_timeout;
  logic                    w_err;

  assign w_req      = cpu_read | cpu_write;
  assign w_page     = cpu_addr[ADDR_WIDTH-1 -: PAGE_BITS];
  assign w_sel_wait = |(t_wait & r_sel);
  assign w_cnt_max  = (r_cnt == CNT_W'(TIMEOUT));
  assign w_unmapped = (r_state == S_IDLE) && w_req && !(|w_hit);
  assign w_timeout  = (r_state == S_ACTIVE) && w_sel_wait && w_cnt_max;
  assign w_err      = w_unmapped | w_timeout;

  // Page decode: one-hot hit vector, lowest index wins on overlapping windows.
  always_comb begin
    w_hit = '0;
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      if (!(|w_hit) &&
          w_page >= TARGET_BASE[i*PAGE_BITS +: PAGE_BITS] &&
          w_page <= TARGET_LAST[i*PAGE_BITS +: PAGE_BITS]) begin
        w_hit[i] = 1'b1;
      end
    end
  end

  // Read-data mux for the latched target.
  always_comb begin
    w_sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      if (r_sel[i]) begin
        w_sel_rdata = t_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_req) w_next = (|w_hit) ? S_ACTIVE : S_DONE;
      S_ACTIVE: if (!w_sel_wait || w_cnt_max) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs: strobes only while ACTIVE, so reset drops them asynchronously.
  always_comb begin
    cpu_wait = 1'b0;
    t_read   = '0;
    t_write  = '0;
    case (r_state)
      S_IDLE:   cpu_wait = w_req;
      S_ACTIVE: begin
        cpu_wait = 1'b1;
        if (r_is_write) t_write = r_sel;
        else            t_read  = r_sel;
      end
      default:  cpu_wait = 1'b0;
    endcase
  end

  // Request latch, watchdog and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel      <= '0;
      r_is_write <= 1'b0;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_req) begin
          r_addr     <= cpu_addr;
          r_wdata    <= cpu_wdata;
          r_is_write <= cpu_write;
          r_sel      <= w_hit;
          r_cnt      <= '0;
          if (!(|w_hit)) r_rdata <= ERR_DATA;
        end
        S_ACTIVE: begin
          if (!w_sel_wait)    r_rdata <= w_sel_rdata;
          else if (w_cnt_max) r_rdata <= ERR_DATA;
          else                r_cnt   <= CNT_W'(r_cnt + 1'b1);
        end
        default: ;
      endcase
    end
  end

  // Sticky first-error log; a new error beats a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_valid   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_addr    <= '0;
    end else if (w_err && (!r_err_valid || err_clear)) begin
      r_err_valid   <= 1'b1;
      r_err_timeout <= w_timeout;
      r_err_addr    <= w_timeout ? r_addr : cpu_addr;
    end else if (err_clear) begin
      r_err_valid   <= 1'b0;
    end
  end

  assign cpu_rdata   = r_rdata;
  assign t_addr      = r_addr;
  assign t_wdata     = r_wdata;
  assign err_valid   = r_err_valid;
  assign err_timeout = r_err_timeout;
  assign err_addr    = r_err_addr;

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric with a completion scoreboard.
module tb_bus_fabric;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned NT = 3;
  localparam int unsigned TO = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [AW-1:0]   cpu_addr = '0;
  logic [DW-1:0]   cpu_wdata = '0;
  logic            cpu_read = 1'b0;
  logic            cpu_write = 1'b0;
  logic [DW-1:0]   cpu_rdata;
  logic            cpu_wait;
  logic [AW-1:0]   t_addr;
  logic [DW-1:0]   t_wdata;
  logic [NT-1:0]   t_read;
  logic [NT-1:0]   t_write;
  logic [NT*DW-1:0] t_rdata;
  logic [NT-1:0]   t_wait = '0;
  logic            err_valid;
  logic            err_timeout;
  logic [AW-1:0]   err_addr;
  logic            err_clear = 1'b0;

  logic [DW-1:0] tdata [NT];

  typedef struct {
    logic [DW-1:0] rdata;
    int            done;
    bit            chk_rdata;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  bus_fabric #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_TARGETS(NT),
    .PAGE_BITS  (8),
    .TARGET_BASE({8'hFF, 8'h80, 8'h00}),
    .TARGET_LAST({8'hFF, 8'hBF, 8'h7F}),
    .TIMEOUT    (TO),
    .ERR_DATA   (8'hFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_rdata  (cpu_rdata),
    .cpu_wait   (cpu_wait),
    .t_addr     (t_addr),
    .t_wdata    (t_wdata),
    .t_read     (t_read),
    .t_write    (t_write),
    .t_rdata    (t_rdata),
    .t_wait     (t_wait),
    .err_valid  (err_valid),
    .err_timeout(err_timeout),
    .err_addr   (err_addr),
    .err_clear  (err_clear)
  );

  always #5 clk = ~clk;

  initial begin
    tdata[0] = 8'h3E;
    tdata[1] = 8'h51;
    tdata[2] = 8'hC7;
  end
  assign t_rdata = {tdata[2], tdata[1], tdata[0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction; tgt<0 means unmapped, k<0 means the target never releases wait.
  // The request is left asserted on return; the caller drops or replaces it.
  task automatic txn(input logic [AW-1:0] addr, input logic [DW-1:0] wd, input bit wr,
                     input int tgt, input int k, input bit clr);
    exp_t e;
    exp_t got;
    logic [NT-1:0] es;
    bit finished;
    e.done      = (tgt < 0) ? 1 : ((k < 0) ? int'(TO) + 2 : 2 + k);
    e.rdata     = (tgt < 0 || k < 0) ? 8'hFF : tdata[tgt];
    e.chk_rdata = !wr;
    sb.push_back(e);
    finished = 1'b0;
    @(posedge clk); #1;
    cpu_addr  = addr;
    cpu_wdata = wd;
    cpu_read  = !wr;
    cpu_write = wr;
    err_clear = clr;
    t_wait    = '0;
    for (int c = 0; c < 400 && !finished; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        err_clear = 1'b0;
        if (tgt >= 0) t_wait[tgt] = (k < 0) || (c <= k);
      end
      @(negedge clk);
      es = (tgt >= 0 && c >= 1 && c < e.done) ? NT'(1 << tgt) : '0;
      chk("t_read", 32'(t_read), 32'(wr ? '0 : es));
      chk("t_write", 32'(t_write), 32'(wr ? es : '0));
      if (es != '0) begin
        chk("t_addr", 32'(t_addr), 32'(addr));
        if (wr) chk("t_wdata", 32'(t_wdata), 32'(wd));
      end
      if (c > 0 && !cpu_wait) begin
        finished = 1'b1;
        if (sb.size() == 0) begin
          chk("sb_empty", 32'(1), 32'(0));
        end else begin
          got = sb.pop_front();
          chk("done_cycle", 32'(c), 32'(got.done));
          if (got.chk_rdata) chk("cpu_rdata", 32'(cpu_rdata), 32'(got.rdata));
        end
      end else begin
        chk("cpu_wait", 32'(cpu_wait), 32'(1));
      end
    end
    if (!finished) chk("completion_bound", 32'(0), 32'(1));
  endtask

  task automatic drop_req();
    @(posedge clk); #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    t_wait    = '0;
    err_clear = 1'b0;
  endtask

  initial begin
    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_wait", 32'(cpu_wait), 32'(0));
    chk("rst_t_read", 32'(t_read), 32'(0));
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
    chk("rst_err_valid", 32'(err_valid), 32'(0));
    @(posedge clk); #1 rst = 1'b0;

    // zero-wait read from target0
    txn(16'h0010, 8'h00, 1'b0, 0, 0, 1'b0);
    drop_req();
    chk("rd0_err_valid", 32'(err_valid), 32'(0));

    // write to target1 with 3 wait cycles
    txn(16'h9000, 8'hA5, 1'b1, 1, 3, 1'b0);
    drop_req();
    chk("wr1_err_valid", 32'(err_valid), 32'(0));

    // read from hung target2 -> timeout
    txn(16'hFF02, 8'h00, 1'b0, 2, -1, 1'b0);
    drop_req();
    @(negedge clk);
    chk("to_err_valid", 32'(err_valid), 32'(1));
    chk("to_err_timeout", 32'(err_timeout), 32'(1));
    chk("to_err_addr", 32'(err_addr), 32'(16'hFF02));

    // plain clear
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
    @(negedge clk);
    chk("clr_err_valid", 32'(err_valid), 32'(0));

    // unmapped accesses and sticky log
    txn(16'hC000, 8'h00, 1'b0, -1, 0, 1'b0);
    drop_req();
    @(negedge clk);
    chk("um_err_valid", 32'(err_valid), 32'(1));
    chk("um_err_timeout", 32'(err_timeout), 32'(0));
    chk("um_err_addr", 32'(err_addr), 32'(16'hC000));
    txn(16'hC001, 8'h00, 1'b0, -1, 0, 1'b0);
    drop_req();
    @(negedge clk);
    chk("um2_err_addr", 32'(err_addr), 32'(16'hC000));
    txn(16'hC002, 8'h00, 1'b0, -1, 0, 1'b1);
    drop_req();
    @(negedge clk);
    chk("um3_err_valid", 32'(err_valid), 32'(1));
    chk("um3_err_addr", 32'(err_addr), 32'(16'hC002));

    // reset in cycle 2 of a waited read
    @(posedge clk); #1;
    cpu_addr = 16'h9002; cpu_read = 1'b1; t_wait = 3'b010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_t_read", 32'(t_read), 32'(3'b010));
    #1 rst = 1'b1; cpu_read = 1'b0;
    #1;
    chk("mid_rst_t_read", 32'(t_read), 32'(0));
    chk("mid_rst_t_write", 32'(t_write), 32'(0));
    chk("mid_rst_cpu_wait", 32'(cpu_wait), 32'(0));
    chk("mid_rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
    chk("mid_rst_t_addr", 32'(t_addr), 32'(0));
    chk("mid_rst_err_valid", 32'(err_valid), 32'(0));
    chk("mid_rst_err_addr", 32'(err_addr), 32'(0));
    @(posedge clk); #1 rst = 1'b0; t_wait = '0;

    // back-to-back reads with the strobe held continuously
    txn(16'h0010, 8'h00, 1'b0, 0, 0, 1'b0);
    txn(16'h9001, 8'h00, 1'b0, 1, 0, 1'b0);
    drop_req();
    chk("sb_drained", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
